// File: rtl/spi_flash_read_scheduler.sv
// Quad-SPI flash read scheduler: shares one shift engine between
// instruction fetch (0) and DMA/bootloader (1) with burst splitting.
module spi_flash_read_scheduler #(
    parameter int MAX_BURST = 64,
    parameter int TIMEOUT   = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic [23:0] addr0,
    input  logic [9:0]  len0,
    input  logic        req1,
    input  logic [23:0] addr1,
    input  logic [9:0]  len1,
    output logic        grant0,
    output logic        grant1,
    output logic [31:0] rdData,
    output logic        rdValid0,
    output logic        rdValid1,
    output logic        done0,
    output logic        done1,
    output logic        error0,
    output logic        error1,
    output logic        busy,
    output logic        shiftStart,
    output logic [23:0] shiftAddress,
    output logic [7:0]  shiftNrOfWords,
    input  logic        shiftDataValid,
    input  logic [31:0] shiftData,
    input  logic        shiftBusy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_DATA,
        S_GAP,
        S_DONE,
        S_ABORT
    } state_t;

    state_t      state_q;
    logic        owner_q;
    logic        rr_q;
    logic [23:0] curAddr_q;
    logic [10:0] remaining_q;
    logic [8:0]  burstLeft_q;
    logic [8:0]  burstLen_q;
    logic [15:0] wdog_q;

    logic        win_d;
    logic [9:0]  lenSel_d;
    logic [23:0] addrSel_d;
    logic [10:0] burst_d;
    logic        dataHit_d;

    // rr_q names the requester that wins a tie; a lone request always wins
    assign win_d     = (req0 && req1) ? rr_q : req1;
    assign lenSel_d  = win_d ? len1 : len0;
    assign addrSel_d = win_d ? addr1 : addr0;
    assign burst_d   = (remaining_q > 11'(MAX_BURST)) ? 11'(MAX_BURST)
                                                      : remaining_q;

    // Returned words go straight through to the owner in the same cycle
    assign dataHit_d = (state_q == S_DATA) && shiftDataValid;
    assign rdData    = dataHit_d ? shiftData : 32'd0;
    assign rdValid0  = dataHit_d && !owner_q;
    assign rdValid1  = dataHit_d && owner_q;
    assign busy      = (state_q != S_IDLE);

    // Scheduler FSM with registered grant/done/error/engine-command outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            owner_q        <= 1'b0;
            rr_q           <= 1'b0;
            curAddr_q      <= 24'd0;
            remaining_q    <= 11'd0;
            burstLeft_q    <= 9'd0;
            burstLen_q     <= 9'd0;
            wdog_q         <= 16'd0;
            grant0         <= 1'b0;
            grant1         <= 1'b0;
            done0          <= 1'b0;
            done1          <= 1'b0;
            error0         <= 1'b0;
            error1         <= 1'b0;
            shiftStart     <= 1'b0;
            shiftAddress   <= 24'd0;
            shiftNrOfWords <= 8'd0;
        end else begin
            grant0     <= 1'b0;
            grant1     <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            error0     <= 1'b0;
            error1     <= 1'b0;
            shiftStart <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        state_q     <= S_GRANT;
                        owner_q     <= win_d;
                        rr_q        <= ~win_d;
                        grant0      <= ~win_d;
                        grant1      <= win_d;
                        curAddr_q   <= {addrSel_d[23:2], 2'b00};
                        remaining_q <= {lenSel_d == 10'd0, lenSel_d};
                    end
                end
                S_GRANT: begin
                    state_q <= S_START;
                end
                S_START: begin
                    if (!shiftBusy) begin
                        shiftStart     <= 1'b1;
                        shiftAddress   <= curAddr_q;
                        shiftNrOfWords <= 8'(burst_d - 11'd1);
                        burstLeft_q    <= 9'(burst_d);
                        burstLen_q     <= 9'(burst_d);
                        wdog_q         <= 16'd0;
                        state_q        <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (shiftDataValid) begin
                        wdog_q      <= 16'd0;
                        burstLeft_q <= burstLeft_q - 9'd1;
                        remaining_q <= remaining_q - 11'd1;
                        if (burstLeft_q == 9'd1) begin
                            curAddr_q <= curAddr_q
                                       + {13'd0, burstLen_q, 2'b00};
                        end
                        if (remaining_q == 11'd1) begin
                            state_q <= S_DONE;
                            done0   <= ~owner_q;
                            done1   <= owner_q;
                        end else if (burstLeft_q == 9'd1) begin
                            state_q <= S_GAP;
                        end
                    end else if (wdog_q == 16'(TIMEOUT - 1)) begin
                        state_q <= S_ABORT;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                S_GAP: begin
                    if (!shiftBusy) begin
                        state_q <= S_START;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                S_ABORT: begin
                    if (!shiftBusy) begin
                        state_q <= S_DONE;
                        done0   <= ~owner_q;
                        done1   <= owner_q;
                        error0  <= ~owner_q;
                        error1  <= owner_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_read_scheduler.sv
// Bench for spi_flash_read_scheduler: two instances (burst 64 and 2)
// each driven by a behavioural quad-SPI engine model.
module tb_spi_flash_read_scheduler;

    localparam int MB0 = 64;
    localparam int MB1 = 2;
    localparam int TO  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req0 [2];
    logic        req1 [2];
    logic [23:0] addr0 [2];
    logic [23:0] addr1 [2];
    logic [9:0]  len0 [2];
    logic [9:0]  len1 [2];
    logic        grant0 [2];
    logic        grant1 [2];
    logic [31:0] rdData [2];
    logic        rdValid0 [2];
    logic        rdValid1 [2];
    logic        done0 [2];
    logic        done1 [2];
    logic        error0 [2];
    logic        error1 [2];
    logic        busy [2];
    logic        sStart [2];
    logic [23:0] sAddr [2];
    logic [7:0]  sNr [2];
    logic        sValid [2];
    logic [31:0] sData [2];
    logic        sBusy [2];

    int checks = 0;
    int errors = 0;
    // index 2*e+r: data for requester r of dut e; 4+e: engine starts
    logic [31:0] expQ [6][$];
    logic [31:0] obsQ [6][$];
    int grantCnt [4];
    int doneCnt [4];

    int gap [2];
    int stallAfter [2];
    int stallLen [2];
    int eLeft [2];
    int eCnt [2];
    int eSent [2];
    int eStall [2];
    logic [23:0] eAddr [2];

    spi_flash_read_scheduler #(.MAX_BURST(MB0), .TIMEOUT(TO)) dut0 (
        .clock(clk), .reset(rst),
        .req0(req0[0]), .addr0(addr0[0]), .len0(len0[0]),
        .req1(req1[0]), .addr1(addr1[0]), .len1(len1[0]),
        .grant0(grant0[0]), .grant1(grant1[0]), .rdData(rdData[0]),
        .rdValid0(rdValid0[0]), .rdValid1(rdValid1[0]),
        .done0(done0[0]), .done1(done1[0]),
        .error0(error0[0]), .error1(error1[0]), .busy(busy[0]),
        .shiftStart(sStart[0]), .shiftAddress(sAddr[0]),
        .shiftNrOfWords(sNr[0]), .shiftDataValid(sValid[0]),
        .shiftData(sData[0]), .shiftBusy(sBusy[0])
    );

    spi_flash_read_scheduler #(.MAX_BURST(MB1), .TIMEOUT(TO)) dut1 (
        .clock(clk), .reset(rst),
        .req0(req0[1]), .addr0(addr0[1]), .len0(len0[1]),
        .req1(req1[1]), .addr1(addr1[1]), .len1(len1[1]),
        .grant0(grant0[1]), .grant1(grant1[1]), .rdData(rdData[1]),
        .rdValid0(rdValid0[1]), .rdValid1(rdValid1[1]),
        .done0(done0[1]), .done1(done1[1]),
        .error0(error0[1]), .error1(error1[1]), .busy(busy[1]),
        .shiftStart(sStart[1]), .shiftAddress(sAddr[1]),
        .shiftNrOfWords(sNr[1]), .shiftDataValid(sValid[1]),
        .shiftData(sData[1]), .shiftBusy(sBusy[1])
    );

    function automatic logic [31:0] wordAt(input logic [23:0] a);
        return {~a[7:0], a};
    endfunction

    // Engine model: one word every gap cycles, optional stall after N words
    always @(posedge clk or posedge rst) begin
        for (int e = 0; e < 2; e++) begin
            if (rst) begin
                sValid[e] <= 1'b0;
                sData[e]  <= 32'd0;
                sBusy[e]  <= 1'b0;
                eLeft[e]  <= 0;
                eCnt[e]   <= 0;
                eSent[e]  <= 0;
                eStall[e] <= 0;
                eAddr[e]  <= 24'd0;
            end else begin
                sValid[e] <= 1'b0;
                if (sStart[e]) begin
                    sBusy[e]  <= 1'b1;
                    eLeft[e]  <= int'(sNr[e]) + 1;
                    eAddr[e]  <= sAddr[e];
                    eCnt[e]   <= 0;
                    eSent[e]  <= 0;
                    eStall[e] <= 0;
                end else if (sBusy[e]) begin
                    if (stallAfter[e] >= 0 && eSent[e] == stallAfter[e]) begin
                        eStall[e] <= eStall[e] + 1;
                        if (eStall[e] == stallLen[e] - 1) sBusy[e] <= 1'b0;
                    end else if (eCnt[e] >= gap[e] - 1) begin
                        sValid[e] <= 1'b1;
                        sData[e]  <= wordAt(eAddr[e]);
                        eAddr[e]  <= eAddr[e] + 24'd4;
                        eLeft[e]  <= eLeft[e] - 1;
                        eCnt[e]   <= 0;
                        eSent[e]  <= eSent[e] + 1;
                        if (eLeft[e] == 1) sBusy[e] <= 1'b0;
                    end else begin
                        eCnt[e] <= eCnt[e] + 1;
                    end
                end
            end
        end
    end

    // Monitor: record DUT outputs into observation queues
    always @(negedge clk) begin
        for (int e = 0; e < 2; e++) begin
            if (sStart[e]) obsQ[4+e].push_back({sAddr[e], sNr[e]});
            if (rdValid0[e]) obsQ[2*e].push_back(rdData[e]);
            if (rdValid1[e]) obsQ[2*e+1].push_back(rdData[e]);
            if (grant0[e]) grantCnt[2*e]++;
            if (grant1[e]) grantCnt[2*e+1]++;
            if (done0[e]) doneCnt[2*e]++;
            if (done1[e]) doneCnt[2*e+1]++;
        end
    end

    task automatic issue(input int e, input int r, input logic [23:0] a,
                         input logic [9:0] l, input int nexp);
        int mb;
        int rem;
        int b;
        logic [23:0] p;
        mb  = (e == 0) ? MB0 : MB1;
        rem = (l == 10'd0) ? 1024 : int'(l);
        p   = {a[23:2], 2'b00};
        for (int i = 0; i < nexp; i++)
            expQ[2*e+r].push_back(wordAt(p + 24'(4 * i)));
        while (rem > 0) begin
            b = (rem < mb) ? rem : mb;
            expQ[4+e].push_back({p, 8'(b - 1)});
            p = p + 24'(4 * b);
            rem = rem - b;
        end
        if (r == 0) begin
            addr0[e] = a; len0[e] = l; req0[e] = 1'b1;
        end else begin
            addr1[e] = a; len1[e] = l; req1[e] = 1'b1;
        end
    endtask

    task automatic wait_grant(input int e, input int r, output int n,
                              output logic [1:0] g);
        n = 0;
        while (!(grant0[e] || grant1[e]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        g = {grant1[e], grant0[e]};
        if (r == 0) req0[e] = 1'b0;
        else req1[e] = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int e, input int r, input int lim,
                             output int n, output logic err);
        n = 0;
        while (!((r == 0) ? done0[e] : done1[e]) && n < lim) begin
            @(negedge clk);
            n++;
        end
        err = (r == 0) ? error0[e] : error1[e];
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant0[0], grant1[0], rdValid0[0], rdValid1[0], done0[0],
             done1[0], error0[0], error1[0], busy[0], sStart[0]} !== 10'd0) begin
            errors++;
            $display("FAIL reset_ctl got %b%b%b%b%b%b%b%b%b%b required 0",
                     grant0[0], grant1[0], rdValid0[0], rdValid1[0], done0[0],
                     done1[0], error0[0], error1[0], busy[0], sStart[0]);
        end
        checks++;
        if ({sAddr[0], sNr[0]} !== 32'd0) begin
            errors++;
            $display("FAIL reset_cmd got %h/%h required 0", sAddr[0], sNr[0]);
        end
        checks++;
        if (rdData[0] !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got %h required 0", rdData[0]);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got %b required 0", busy[0]);
        end
    endtask

    task automatic test_single();
        int n;
        int g0;
        logic [1:0] g;
        logic err;
        logic [31:0] ex;
        logic [31:0] ob;
        gap[0] = 10;
        g0 = grantCnt[0];
        issue(0, 0, 24'h001000, 10'd4, 4);
        wait_grant(0, 0, n, g);
        checks++;
        if (n >= 200 || g !== 2'b01) begin
            errors++;
            $display("FAIL single_grant got %b after %0d required 01", g, n);
        end
        wait_done(0, 0, 400, n, err);
        checks++;
        if (n >= 400 || err !== 1'b0) begin
            errors++;
            $display("FAIL single_done got err %b after %0d required 0", err, n);
        end
        checks++;
        if (grantCnt[0] - g0 !== 1) begin
            errors++;
            $display("FAIL single_grant_once got %0d required 1", grantCnt[0] - g0);
        end
        for (int k = 0; k < 6; k++)
            while (expQ[k].size() > 0 || obsQ[k].size() > 0) begin
                checks++;
                if (expQ[k].size() == 0 || obsQ[k].size() == 0) begin
                    errors++;
                    $display("FAIL single_sb%0d got %0d items required %0d",
                             k, obsQ[k].size(), expQ[k].size());
                    expQ[k].delete(); obsQ[k].delete();
                end else begin
                    ex = expQ[k].pop_front(); ob = obsQ[k].pop_front();
                    if (ob !== ex) begin
                        errors++;
                        $display("FAIL single_sb%0d got %h required %h", k, ob, ex);
                    end
                end
            end
    endtask

    task automatic test_burst_split();
        int n;
        int d1;
        logic [1:0] g;
        logic err;
        logic [31:0] ex;
        logic [31:0] ob;
        gap[0] = 1;
        d1 = doneCnt[1];
        issue(0, 1, 24'h0FFF00, 10'd150, 150);
        wait_grant(0, 1, n, g);
        checks++;
        if (n >= 200 || g !== 2'b10) begin
            errors++;
            $display("FAIL split_grant got %b after %0d required 10", g, n);
        end
        wait_done(0, 1, 2000, n, err);
        checks++;
        if (n >= 2000 || err !== 1'b0) begin
            errors++;
            $display("FAIL split_done got err %b after %0d required 0", err, n);
        end
        checks++;
        if (doneCnt[1] - d1 !== 1) begin
            errors++;
            $display("FAIL split_done_once got %0d required 1", doneCnt[1] - d1);
        end
        for (int k = 0; k < 6; k++)
            while (expQ[k].size() > 0 || obsQ[k].size() > 0) begin
                checks++;
                if (expQ[k].size() == 0 || obsQ[k].size() == 0) begin
                    errors++;
                    $display("FAIL split_sb%0d got %0d items required %0d",
                             k, obsQ[k].size(), expQ[k].size());
                    expQ[k].delete(); obsQ[k].delete();
                end else begin
                    ex = expQ[k].pop_front(); ob = obsQ[k].pop_front();
                    if (ob !== ex) begin
                        errors++;
                        $display("FAIL split_sb%0d got %h required %h", k, ob, ex);
                    end
                end
            end
    endtask

    task automatic test_wrap();
        int n;
        logic [1:0] g;
        logic err;
        logic [31:0] ex;
        logic [31:0] ob;
        gap[1] = 2;
        issue(1, 0, 24'hFFFFF8, 10'd4, 4);
        wait_grant(1, 0, n, g);
        checks++;
        if (n >= 200 || g !== 2'b01) begin
            errors++;
            $display("FAIL wrap_grant got %b after %0d required 01", g, n);
        end
        wait_done(1, 0, 300, n, err);
        checks++;
        if (n >= 300 || err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done got err %b after %0d required 0", err, n);
        end
        for (int k = 0; k < 6; k++)
            while (expQ[k].size() > 0 || obsQ[k].size() > 0) begin
                checks++;
                if (expQ[k].size() == 0 || obsQ[k].size() == 0) begin
                    errors++;
                    $display("FAIL wrap_sb%0d got %0d items required %0d",
                             k, obsQ[k].size(), expQ[k].size());
                    expQ[k].delete(); obsQ[k].delete();
                end else begin
                    ex = expQ[k].pop_front(); ob = obsQ[k].pop_front();
                    if (ob !== ex) begin
                        errors++;
                        $display("FAIL wrap_sb%0d got %h required %h", k, ob, ex);
                    end
                end
            end
    endtask

    task automatic test_contention();
        int n;
        logic [1:0] g;
        logic err;
        logic [31:0] ex;
        logic [31:0] ob;
        logic [1:0] want [4];
        want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        gap[0] = 3;
        issue(0, 0, 24'h000100, 10'd2, 2);
        issue(0, 1, 24'h000200, 10'd2, 2);
        for (int i = 0; i < 4; i++) begin
            wait_grant(0, i % 2, n, g);
            checks++;
            if (n >= 200 || g !== want[i]) begin
                errors++;
                $display("FAIL rr_grant%0d got %b required %b", i, g, want[i]);
            end
            if (i == 2) issue(0, 1, 24'h000400, 10'd2, 2);
            wait_done(0, i % 2, 200, n, err);
            checks++;
            if (n >= 200 || err !== 1'b0) begin
                errors++;
                $display("FAIL rr_done%0d got err %b after %0d required 0", i, err, n);
            end
            if (i == 0) issue(0, 0, 24'h000300, 10'd2, 2);
        end
        for (int k = 0; k < 6; k++)
            while (expQ[k].size() > 0 || obsQ[k].size() > 0) begin
                checks++;
                if (expQ[k].size() == 0 || obsQ[k].size() == 0) begin
                    errors++;
                    $display("FAIL rr_sb%0d got %0d items required %0d",
                             k, obsQ[k].size(), expQ[k].size());
                    expQ[k].delete(); obsQ[k].delete();
                end else begin
                    ex = expQ[k].pop_front(); ob = obsQ[k].pop_front();
                    if (ob !== ex) begin
                        errors++;
                        $display("FAIL rr_sb%0d got %h required %h", k, ob, ex);
                    end
                end
            end
    endtask

    task automatic test_timeout();
        int n;
        logic [1:0] g;
        logic err;
        logic [31:0] ex;
        logic [31:0] ob;
        gap[0] = 2;
        stallAfter[0] = 1;
        stallLen[0] = 40;
        issue(0, 0, 24'h002000, 10'd3, 1);
        wait_grant(0, 0, n, g);
        checks++;
        if (n >= 200 || g !== 2'b01) begin
            errors++;
            $display("FAIL to_grant got %b after %0d required 01", g, n);
        end
        wait_done(0, 0, 300, n, err);
        checks++;
        if (n >= 300 || err !== 1'b1) begin
            errors++;
            $display("FAIL to_error got err %b after %0d required 1", err, n);
        end
        checks++;
        if (n < 40 || n > 80) begin
            errors++;
            $display("FAIL to_wait_busy got %0d cycles required 40..80", n);
        end
        stallAfter[0] = -1;
        for (int k = 0; k < 6; k++)
            while (expQ[k].size() > 0 || obsQ[k].size() > 0) begin
                checks++;
                if (expQ[k].size() == 0 || obsQ[k].size() == 0) begin
                    errors++;
                    $display("FAIL to_sb%0d got %0d items required %0d",
                             k, obsQ[k].size(), expQ[k].size());
                    expQ[k].delete(); obsQ[k].delete();
                end else begin
                    ex = expQ[k].pop_front(); ob = obsQ[k].pop_front();
                    if (ob !== ex) begin
                        errors++;
                        $display("FAIL to_sb%0d got %h required %h", k, ob, ex);
                    end
                end
            end
    endtask

    task automatic test_async_reset();
        int n;
        logic [1:0] g;
        logic err;
        logic [31:0] ex;
        logic [31:0] ob;
        gap[0] = 10;
        issue(0, 0, 24'h003000, 10'd8, 8);
        wait_grant(0, 0, n, g);
        n = 0;
        while (obsQ[0].size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre got busy %b after %0d required 1", busy[0], n);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy[0], sStart[0], rdValid0[0], rdValid1[0], grant0[0],
             done0[0], error0[0]} !== 7'd0 || rdData[0] !== 32'd0) begin
            errors++;
            $display("FAIL ar_async got busy %b start %b valid %b data %h required 0",
                     busy[0], sStart[0], rdValid0[0], rdData[0]);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            expQ[k].delete();
            obsQ[k].delete();
        end
        @(negedge clk);
        issue(0, 0, 24'h004000, 10'd1, 1);
        wait_grant(0, 0, n, g);
        checks++;
        if (n >= 200 || g !== 2'b01) begin
            errors++;
            $display("FAIL ar_grant got %b after %0d required 01", g, n);
        end
        wait_done(0, 0, 300, n, err);
        checks++;
        if (n >= 300 || err !== 1'b0) begin
            errors++;
            $display("FAIL ar_done got err %b after %0d required 0", err, n);
        end
        for (int k = 0; k < 6; k++)
            while (expQ[k].size() > 0 || obsQ[k].size() > 0) begin
                checks++;
                if (expQ[k].size() == 0 || obsQ[k].size() == 0) begin
                    errors++;
                    $display("FAIL ar_sb%0d got %0d items required %0d",
                             k, obsQ[k].size(), expQ[k].size());
                    expQ[k].delete(); obsQ[k].delete();
                end else begin
                    ex = expQ[k].pop_front(); ob = obsQ[k].pop_front();
                    if (ob !== ex) begin
                        errors++;
                        $display("FAIL ar_sb%0d got %h required %h", k, ob, ex);
                    end
                end
            end
    endtask

    initial begin
        rst = 1'b1;
        for (int e = 0; e < 2; e++) begin
            req0[e] = 1'b0; req1[e] = 1'b0;
            addr0[e] = 24'd0; addr1[e] = 24'd0;
            len0[e] = 10'd0; len1[e] = 10'd0;
            gap[e] = 2; stallAfter[e] = -1; stallLen[e] = 0;
        end
        test_reset();
        test_single();
        test_burst_split();
        test_wrap();
        test_contention();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
